// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic int unsigned calc_nstep(int unsigned width, int unsigned digit);
        return (digit == 0) ? 1 : width / digit;
    endfunction

    // Counter holds 0..nstep-1; never narrower than one bit.
    function automatic int unsigned cnt_width(int unsigned nstep);
        return (nstep <= 2) ? 1 : unsigned'($clog2(nstep));
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder used as one slice of the digit ripple.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ c;
    assign co = (x & y) | (x & c) | (y & c);

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial add/subtract with registered carry and valid/ready handshakes.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_digit_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NSTEP = calc_nstep(WIDTH, DIGIT);
    localparam int unsigned CntW  = cnt_width(NSTEP);
    localparam logic [CntW-1:0] LastCnt = CntW'(NSTEP - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_digit_adder: WIDTH must be >=1 and a multiple of DIGIT>=1");
    end

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic [DIGIT-1:0]  dsum;
    logic [DIGIT:0]    dcarry;

    assign dcarry[0] = carry_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_ripple
        fa_cell u_fa (
            .x  (a_q[i]),
            .y  (b_q[i]),
            .c  (dcarry[i]),
            .s  (dsum[i]),
            .co (dcarry[i+1])
        );
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
    assign ovf = ovf_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Result digits enter at the top so the LSB digit lands at bit 0 after NSTEP shifts.
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                sum_d = sum_q >> DIGIT;
                sum_d[WIDTH-1 -: DIGIT] = dsum;
                carry_d = dcarry[DIGIT];
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    cout_d  = dcarry[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = dcarry[DIGIT] ^ dcarry[DIGIT-1];
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
